main_stream_sched: RTL and testbench

- Run controller for the Coriolis kernel stream pipeline. It sits between the host-side stream interfaces and the kernel's shared ivalid/iready/ovalid/oready handshake.
- Sequences one job of N elements across the four lock-stepped input streams (u, v, x, y) and the four output streams (un, vn, xn, yn).
- Bounds the number of in-flight elements with a credit counter, counts accepted inputs and emitted outputs, and reports done, cycle count and protocol errors.
- Data buses do not pass through the block. It gates handshakes only.

---
 rtl/main_stream_sched_if.sv | 30 +++
 rtl/main_stream_sched.sv | 97 +++++++++
 tb/tb_main_stream_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/main_stream_sched_if.sv
// Handshake and job-control bundle between the host streams, the Coriolis kernel
// and the run controller. The scheduler takes the slave view.
interface main_stream_sched_if #(
   parameter int NW = 32
);
   logic          start;
   logic [NW-1:0] nelem;
   logic          busy;
   logic          done;
   logic          err;
   logic [NW-1:0] cyc_cnt;
   logic          src_valid;
   logic          src_ready;
   logic          k_ivalid;
   logic          k_iready;
   logic          k_ovalid;
   logic          k_oready;
   logic          snk_valid;
   logic          snk_ready;

   modport slave (
      input  start, nelem, src_valid, k_iready, k_ovalid, snk_ready,
      output busy, done, err, cyc_cnt, src_ready, k_ivalid, k_oready, snk_valid
   );

   modport master (
      output start, nelem, src_valid, k_iready, k_ovalid, snk_ready,
      input  busy, done, err, cyc_cnt, src_ready, k_ivalid, k_oready, snk_valid
   );
endinterface

// File: rtl/main_stream_sched.sv
// Run controller for the Coriolis stream kernel: sequences one N-element job,
// bounds in-flight elements with a credit counter and flags spurious outputs.
module main_stream_sched #(
   parameter int NW          = 32,
   parameter int MAXINFLIGHT = 16,
   parameter int IFW         = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   main_stream_sched_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state;
   logic [NW-1:0]   n;
   logic [NW-1:0]   in_cnt;
   logic [NW-1:0]   out_cnt;
   logic [IFW-1:0]  inflight;

   logic in_gate, out_gate, credit_ok;
   logic in_acc, out_acc, in_last, out_last;
   logic inc, dec, err_set;

   assign in_gate   = (state == RUN);
   assign out_gate  = (state == RUN) || (state == DRAIN);
   assign credit_ok = (inflight < IFW'(MAXINFLIGHT));

   assign bus.k_ivalid  = in_gate & bus.src_valid & credit_ok;
   assign bus.src_ready = in_gate & bus.k_iready & credit_ok;
   assign bus.snk_valid = out_gate & bus.k_ovalid;
   assign bus.k_oready  = out_gate & bus.snk_ready;

   assign in_acc   = in_gate & bus.src_valid & bus.k_iready & credit_ok;
   assign out_acc  = out_gate & bus.k_ovalid & bus.snk_ready;
   assign in_last  = in_acc && ((in_cnt + NW'(1)) == n);
   assign out_last = out_acc && ((out_cnt + NW'(1)) == n);

   // Credit is only returned for elements actually counted as in flight.
   assign inc     = in_acc;
   assign dec     = out_acc && (inflight != '0);
   assign err_set = bus.k_ovalid && (!out_gate || (inflight == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         n           <= '0;
         in_cnt      <= '0;
         out_cnt     <= '0;
         inflight    <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
         bus.cyc_cnt <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= bus.err | err_set;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  in_cnt      <= '0;
                  out_cnt     <= '0;
                  inflight    <= '0;
                  bus.cyc_cnt <= '0;
                  bus.err     <= err_set;
                  if (bus.nelem == '0) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     n        <= bus.nelem;
                     state    <= RUN;
                     bus.busy <= 1'b1;
                  end
               end
            end
            RUN, DRAIN: begin
               if (in_acc) in_cnt <= in_cnt + NW'(1);
               if (out_acc && (out_cnt != n)) out_cnt <= out_cnt + NW'(1);
               if (inc && !dec) inflight <= inflight + IFW'(1);
               else if (dec && !inc) inflight <= inflight - IFW'(1);
               if (bus.cyc_cnt != '1) bus.cyc_cnt <= bus.cyc_cnt + NW'(1);
               if ((state == RUN && in_last && out_last) ||
                   (state == DRAIN && out_last)) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end else if (state == RUN && in_last) begin
                  state <= DRAIN;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_main_stream_sched.sv
// Directed bench for main_stream_sched with a fixed-latency kernel model and
// host counters for accepted inputs/outputs.
module tb_main_stream_sched;

   localparam int NW  = 32;
   localparam int LAT = 5;

   logic clk;
   logic rst;

   main_stream_sched_if #(.NW(NW)) bus ();

   main_stream_sched #(.NW(NW), .MAXINFLIGHT(16), .IFW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int tb_cyc = 0;
   int kq[$];

   int n_in, n_out, n_done, peak, gate_bad, busy_bad, done_k, in_at_stall;
   logic [NW-1:0] done_cyc;
   logic first_err, post_done, post_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: called just after a negedge with inputs already driven.
   task automatic tick();
      logic in_acc, out_acc;
      #1;
      in_acc  = bus.src_valid && bus.src_ready;
      out_acc = bus.k_ovalid && bus.k_oready;
      if ((bus.k_ivalid && bus.k_iready) !== in_acc) gate_bad++;
      if ((bus.snk_valid && bus.snk_ready) !== out_acc) gate_bad++;
      if (bus.busy && (bus.snk_valid !== bus.k_ovalid)) gate_bad++;
      if (bus.busy && (bus.k_oready !== bus.snk_ready)) gate_bad++;
      if (in_acc) n_in++;
      if (out_acc) n_out++;
      if (bus.done) n_done++;
      if (n_in - n_out > peak) peak = n_in - n_out;
      @(posedge clk);
      if (in_acc) kq.push_back(tb_cyc);
      if (out_acc && kq.size() > 0) void'(kq.pop_front());
      tb_cyc++;
      @(negedge clk);
      bus.k_ovalid = 1'b0;
      if (kq.size() > 0) begin
         if (tb_cyc - kq[0] >= LAT) bus.k_ovalid = 1'b1;
      end
   endtask

   task automatic clr_stats();
      n_in = 0; n_out = 0; n_done = 0; peak = 0; gate_bad = 0; busy_bad = 0;
      done_k = -1; in_at_stall = -1; done_cyc = '0; first_err = 1'b0;
   endtask

   task automatic run_job(input int n, input int stall, input int restart_k, input int budget);
      clr_stats();
      bus.start     = 1'b1;
      bus.nelem     = NW'(n);
      bus.src_valid = 1'b1;
      bus.k_iready  = 1'b1;
      bus.snk_ready = (stall == 0);
      tick();
      for (int k = 1; k < budget && done_k < 0; k++) begin
         bus.snk_ready = (k >= stall);
         bus.start     = (k == restart_k);
         bus.nelem     = (k == restart_k) ? NW'(99) : '0;
         #1;
         if (k == stall) in_at_stall = n_in;
         if (k == 1) first_err = bus.err;
         if (bus.done) begin
            done_k   = k;
            done_cyc = bus.cyc_cnt;
            if (bus.busy) busy_bad++;
         end else if (!bus.busy) begin
            busy_bad++;
         end
         tick();
      end
      bus.start = 1'b0;
      #1;
      post_done = bus.done;
      post_busy = bus.busy;
      chk("job_timeout", (done_k >= 0), 1);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.nelem = '0; bus.src_valid = 1'b0;
      bus.k_iready = 1'b0; bus.k_ovalid = 1'b0; bus.snk_ready = 1'b0;
      clr_stats();
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      bus.src_valid = 1'b1; bus.k_iready = 1'b1; bus.snk_ready = 1'b1;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_cyc", bus.cyc_cnt, 0);
      chk("rst_gates", {bus.src_ready, bus.k_ivalid, bus.k_oready, bus.snk_valid}, 0);
      @(negedge clk);

      // Basic 8-element job, latency 5, always ready.
      run_job(8, 0, -1, 200);
      chk("t1_in", n_in, 8);
      chk("t1_out", n_out, 8);
      chk("t1_done_pulses", n_done, 1);
      chk("t1_done_k", done_k, 14);
      chk("t1_cyc", done_cyc, 13);
      chk("t1_busy_window", busy_bad, 0);
      chk("t1_peak", peak, 5);
      chk("t1_err", bus.err, 0);
      chk("t1_post_done", post_done, 0);
      chk("t1_gate", gate_bad, 0);
      @(negedge clk);

      // Credit limit: sink stalled for 30 cycles.
      run_job(40, 30, -1, 400);
      chk("t2_in_at_stall", in_at_stall, 16);
      chk("t2_peak", peak, 16);
      chk("t2_in", n_in, 40);
      chk("t2_out", n_out, 40);
      chk("t2_done_pulses", n_done, 1);
      chk("t2_busy_window", busy_bad, 0);
      chk("t2_err", bus.err, 0);
      chk("t2_gate", gate_bad, 0);
      @(negedge clk);

      // Zero-length job.
      clr_stats();
      bus.start = 1'b1; bus.nelem = '0;
      tick();
      bus.start = 1'b0;
      #1;
      chk("t3_done", bus.done, 1);
      chk("t3_busy", bus.busy, 0);
      chk("t3_cyc", bus.cyc_cnt, 0);
      chk("t3_gates_done", {bus.src_ready, bus.k_ivalid, bus.k_oready, bus.snk_valid}, 0);
      tick();
      #1;
      chk("t3_done_drop", bus.done, 0);
      chk("t3_gates_idle", {bus.src_ready, bus.k_ivalid, bus.k_oready, bus.snk_valid}, 0);
      chk("t3_in", n_in, 0);
      @(negedge clk);

      // Reset in the middle of a 10-element job.
      clr_stats();
      bus.start = 1'b1; bus.nelem = NW'(10);
      tick();
      bus.start = 1'b0; bus.nelem = '0;
      for (int k = 1; k <= 3; k++) tick();
      chk("t4_in_before_rst", n_in, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      kq.delete();
      bus.k_ovalid = 1'b0;
      #1;
      chk("t4_busy", bus.busy, 0);
      chk("t4_done", bus.done, 0);
      chk("t4_cyc", bus.cyc_cnt, 0);
      chk("t4_gates", {bus.src_ready, bus.k_ivalid, bus.k_oready, bus.snk_valid}, 0);
      @(negedge clk);
      run_job(4, 0, -1, 100);
      chk("t4_in", n_in, 4);
      chk("t4_out", n_out, 4);
      chk("t4_done_k", done_k, 10);
      chk("t4_cyc_done", done_cyc, 9);
      @(negedge clk);

      // Spurious kernel output while idle.
      bus.k_ovalid = 1'b1;
      #1;
      chk("t5_oready_idle", bus.k_oready, 0);
      chk("t5_snk_valid_idle", bus.snk_valid, 0);
      tick();
      #1;
      chk("t5_err_set", bus.err, 1);
      tick();
      #1;
      chk("t5_err_sticky", bus.err, 1);
      @(negedge clk);
      run_job(4, 0, -1, 100);
      chk("t5_err_cleared", first_err, 0);
      chk("t5_out", n_out, 4);
      chk("t5_err_end", bus.err, 0);
      @(negedge clk);

      // Start while busy is ignored.
      run_job(6, 0, 3, 100);
      chk("t6_in", n_in, 6);
      chk("t6_out", n_out, 6);
      chk("t6_done_k", done_k, 12);
      chk("t6_cyc", done_cyc, 11);
      chk("t6_done_pulses", n_done, 1);
      chk("t6_post_busy", post_busy, 0);
      chk("t6_gate", gate_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
